pipelined_barrel_shifter: RTL

//  Parametrised multi-mode barrel shifter for the EX stage: SLL/SRL/SRA/ROR on a WIDTH-bit

---
 rtl/pipelined_barrel_shifter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Multi-mode (SLL/SRL/SRA/ROR) barrel shifter built from log2(WIDTH) mux levels, with a
// pipeline register after every REG_EVERY levels and valid/ready handshakes on both sides.
module pipelined_barrel_shifter #(
    parameter int WIDTH     = 32,
    parameter int SHAMT_W   = $clog2(WIDTH),
    parameter int REG_EVERY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] sel,
    input  logic [2:0]         Signal,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dataOut,
    output logic               zero
);
    localparam int LAT = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    // One mux level: shift by a fixed power-of-two amount; unknown ops pass data through.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             sign,
        input int               amt
    );
        logic [WIDTH-1:0] fill_s;
        logic [WIDTH-1:0] res_s;
        fill_s = sign ? ~({WIDTH{1'b1}} >> amt) : {WIDTH{1'b0}};
        case (op)
            OP_SLL:  res_s = d << amt;
            OP_SRL:  res_s = d >> amt;
            OP_SRA:  res_s = (d >> amt) | fill_s;
            OP_ROR:  res_s = (d >> amt) | (d << (WIDTH - amt));
            default: res_s = d;
        endcase
        return res_s;
    endfunction

    logic stall_s;
    logic zero_r;

    // A single global stall freezes every stage while the consumer back-pressures.
    assign stall_s  = out_valid && !out_ready;
    assign in_ready = !stall_s;

    for (genvar s = 0; s < LAT; s++) begin : stg
        localparam int LO    = s * REG_EVERY;
        localparam int HI    = (LO + REG_EVERY > SHAMT_W) ? SHAMT_W : LO + REG_EVERY;
        localparam int NL    = HI - LO;
        localparam int SW_IN = SHAMT_W - LO;

        logic [WIDTH-1:0] d_in_s;
        logic [2:0]       op_in_s;
        logic             sign_in_s;
        logic             v_in_s;
        logic [SW_IN-1:0] sel_in_s;
        logic [WIDTH-1:0] nxt_s;
        logic             valid_r;
        logic [WIDTH-1:0] data_r;

        if (s == 0) begin : src
            assign d_in_s    = data;
            assign op_in_s   = Signal;
            assign sign_in_s = data[WIDTH-1];
            assign v_in_s    = in_valid;
            assign sel_in_s  = sel;
        end else begin : src
            assign d_in_s    = stg[s-1].data_r;
            assign op_in_s   = stg[s-1].carry.op_r;
            assign sign_in_s = stg[s-1].carry.sign_r;
            assign v_in_s    = stg[s-1].valid_r;
            assign sel_in_s  = stg[s-1].carry.sel_r;
        end

        // Levels LO..HI-1; sel_in_s holds only the not-yet-consumed shift bits, LSB first.
        for (genvar j = 0; j < NL; j++) begin : lvl
            logic [WIDTH-1:0] prev_s;
            logic [WIDTH-1:0] out_s;
            if (j == 0) begin : p
                assign prev_s = d_in_s;
            end else begin : p
                assign prev_s = lvl[j-1].out_s;
            end
            assign out_s = sel_in_s[j] ? shift_level(prev_s, op_in_s, sign_in_s, 1 << (LO + j))
                                       : prev_s;
        end
        assign nxt_s = lvl[NL-1].out_s;

        // Stage data/valid register; data only loads on a real beat so bubbles keep the last value.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_r <= 1'b0;
                data_r  <= {WIDTH{1'b0}};
            end else if (!stall_s) begin
                valid_r <= v_in_s;
                if (v_in_s) begin
                    data_r <= nxt_s;
                end
            end
        end

        if (s < LAT - 1) begin : carry
            logic [2:0]          op_r;
            logic                sign_r;
            logic [SW_IN-NL-1:0] sel_r;

            // Op, entry sign bit and remaining shift bits travel alongside the data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    op_r   <= 3'b000;
                    sign_r <= 1'b0;
                    sel_r  <= {(SW_IN-NL){1'b0}};
                end else if (!stall_s && v_in_s) begin
                    op_r   <= op_in_s;
                    sign_r <= sign_in_s;
                    sel_r  <= sel_in_s[SW_IN-1:NL];
                end
            end
        end
    end

    // Zero flag lives with the output stage and drops whenever a bubble reaches the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_r <= 1'b0;
        end else if (!stall_s) begin
            zero_r <= stg[LAT-1].v_in_s && (stg[LAT-1].nxt_s == {WIDTH{1'b0}});
        end
    end

    assign out_valid = stg[LAT-1].valid_r;
    assign dataOut   = stg[LAT-1].data_r;
    assign zero      = zero_r;

endmodule
